// File: rtl/sw_debounce.sv
// Per-bit two-flop synchroniser and stability-counter debouncer for slide switches.
// Define SW_DEBOUNCE_EDGE_EN to build the registered rise/fall pulse outputs.
module sw_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] sw_busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // With DEBOUNCE_CYCLES = 1 the commit fires straight from idle since CNT_LAST is 0.
  always_comb begin
    commit  = '0;
    sw_busy = '0;
    for (int i = 0; i < WIDTH; i++) begin
      commit[i]  = (s2[i] != sw_clean[i]) && (cnt[i] == CNT_LAST);
      sw_busy[i] = (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_clean <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == sw_clean[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          sw_clean[i] <= s2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= commit & s2;
      sw_fall <= commit & ~s2;
    end
  end
`else
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Randomised scoreboard bench for sw_debounce (WIDTH=2, DEBOUNCE_CYCLES=4) with a window-based model.
module tb_sw_debounce;

  localparam int W = 2;
  localparam int D = 4;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] busy;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic [W-1:0] sw_busy;

  int testsRun  = 0;
  int testsFail = 0;

  exp_t         expQ[$];
  logic [W-1:0] rawHist[$];
  logic [W-1:0] syncHist[$];
  logic [W-1:0] mClean;

  sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .sw_clean(sw_clean),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_busy(sw_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compareField(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    testsRun++;
    if (act !== req) begin
      testsFail++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("sw_clean", sw_clean, e.clean);
    compareField("sw_rise", sw_rise, e.rise);
    compareField("sw_fall", sw_fall, e.fall);
    compareField("sw_busy", sw_busy, e.busy);
  endtask

  task automatic modelReset();
    mClean = '0;
    rawHist = {};
    rawHist.push_back('0);
    rawHist.push_back('0);
    syncHist = {};
  endtask

  // The model treats the synchronised value as raw delayed by two edges and commits a bit
  // once that value has disagreed with the clean level on D consecutive edges.
  task automatic applyStimulus(input logic [W-1:0] raw, input logic rst);
    exp_t         e;
    logic         wasRunning;
    logic [W-1:0] sync;
    logic         commit;
    wasRunning = rst_n;
    @(negedge clk);
    sw_raw = raw;
    rst_n  = rst;
    e = '0;
    if (!rst) begin
      modelReset();
      if (wasRunning) begin
        #1;
        checkOutput('0);
      end
    end else begin
      rawHist.push_back(raw);
      sync = rawHist.pop_front();
      syncHist.push_back(sync);
      if (syncHist.size() > D) void'(syncHist.pop_front());
      for (int b = 0; b < W; b++) begin
        commit = (syncHist.size() == D);
        foreach (syncHist[k]) begin
          if (syncHist[k][b] == mClean[b]) commit = 1'b0;
        end
        e.busy[b] = (sync[b] != mClean[b]) && !commit;
        e.rise[b] = EDGE_EN && commit && sync[b];
        e.fall[b] = EDGE_EN && commit && !sync[b];
        if (commit) mClean[b] = sync[b];
      end
      e.clean = mClean;
    end
    expQ.push_back(e);
  endtask

  task automatic holdRaw(input logic [W-1:0] raw, input int n);
    for (int i = 0; i < n; i++) applyStimulus(raw, 1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] v;
    int n;
    rst_n  = 1'b0;
    sw_raw = 2'b11;
    modelReset();
    #1;
    checkOutput('0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b0);
    holdRaw(2'b11, 10);
    holdRaw(2'b01, 10);
    holdRaw(2'b00, 10);
    holdRaw(2'b01, 10);
    holdRaw(2'b00, 10);
    holdRaw(2'b01, 3);
    holdRaw(2'b00, 10);
    holdRaw(2'b10, 1);
    holdRaw(2'b00, 1);
    holdRaw(2'b10, 1);
    holdRaw(2'b00, 1);
    holdRaw(2'b10, 10);
    holdRaw(2'b00, 10);
    holdRaw(2'b01, 4);
    applyStimulus(2'b01, 1'b0);
    applyStimulus(2'b01, 1'b0);
    holdRaw(2'b01, 10);
    for (int t = 0; t < 700; t++) begin
      v = W'($urandom_range(0, 3));
      n = $urandom_range(1, 8);
      if ($urandom_range(0, 99) == 0) begin
        applyStimulus(v, 1'b0);
        applyStimulus(v, 1'b0);
      end
      holdRaw(v, n);
    end
    holdRaw(2'b00, 10);
    repeat (3) @(posedge clk);
    #2;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFail++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
